// File: rtl/map_access_arbiter_if.sv
// Purpose: bundles every map_access_arbiter signal except clock and reset.
// Latency: RAM/ROM read data is expected one cycle after the address.
// Backpressure: rob/ed hold req and fields until their gnt; video has no gnt.
// Ports: slave = arbiter side, master = requesters plus ROM/RAM side.
//   map_reload/ready: re-init request and run status
//   rom_addr/rom_data: initial-map ROM
//   vid_*, rob_*, ed_*: three requester ports
//   ram_*: single-port map RAM; addr_err: out-of-range access flag
interface map_access_arbiter_if;
  logic       map_reload;
  logic       ready;
  logic [8:0] rom_addr;
  logic [3:0] rom_data;
  logic       vid_req;
  logic [3:0] vid_row;
  logic [4:0] vid_col;
  logic       vid_rvalid;
  logic [3:0] vid_rdata;
  logic       rob_req;
  logic       rob_we;
  logic [3:0] rob_row;
  logic [4:0] rob_col;
  logic [3:0] rob_wdata;
  logic       rob_gnt;
  logic       rob_rvalid;
  logic [3:0] rob_rdata;
  logic       ed_req;
  logic [3:0] ed_row;
  logic [4:0] ed_col;
  logic [3:0] ed_wdata;
  logic       ed_gnt;
  logic [8:0] ram_addr;
  logic       ram_we;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata;
  logic       addr_err;

  modport slave (
    input  map_reload, rom_data, vid_req, vid_row, vid_col,
           rob_req, rob_we, rob_row, rob_col, rob_wdata,
           ed_req, ed_row, ed_col, ed_wdata, ram_rdata,
    output ready, rom_addr, vid_rvalid, vid_rdata, rob_gnt, rob_rvalid, rob_rdata,
           ed_gnt, ram_addr, ram_we, ram_wdata, addr_err
  );

  modport master (
    output map_reload, rom_data, vid_req, vid_row, vid_col,
           rob_req, rob_we, rob_row, rob_col, rob_wdata,
           ed_req, ed_row, ed_col, ed_wdata, ram_rdata,
    input  ready, rom_addr, vid_rvalid, vid_rdata, rob_gnt, rob_rvalid, rob_rdata,
           ed_gnt, ram_addr, ram_we, ram_wdata, addr_err
  );
endinterface

// File: rtl/map_access_arbiter.sv
// Purpose: owns the map RAM; copies the ROM in (INIT), then arbitrates video/robot/editor.
// Latency: grant and RAM command in cycle T (combinational); read rvalid/rdata in T+1.
// Backpressure: video always wins; robot/editor round-robin, held off during INIT and reload.
// Ports: clock_50, reset (sync, active-high); bus = map_access_arbiter_if.slave.
module map_access_arbiter #(
  parameter int         ROWS      = 15,
  parameter int         COLS      = 20,
  parameter int         MAP_DEPTH = 321,
  parameter logic [3:0] WALL_CODE = 4'b0000
) (
  input logic                 clock_50,
  input logic                 reset,
  map_access_arbiter_if.slave bus
);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic       RR_ROB  = 1'b0;
  localparam logic       RR_ED   = 1'b1;
  localparam logic [8:0] DEPTH9  = 9'(MAP_DEPTH);
  localparam logic [8:0] COLS9   = 9'(COLS);

  logic [0:0] state_q, state_d;
  logic [8:0] k_q, k_d;
  logic       rr_last_q, rr_last_d;
  logic [8:0] ram_addr_q, ram_addr_d;
  logic       vid_pend_q, vid_pend_d;
  logic       rob_pend_q, rob_pend_d;
  logic       rd_oor_q, rd_oor_d;
  logic       addr_err_q, addr_err_d;
  logic [3:0] vid_rdata_q, vid_rdata_d;
  logic [3:0] rob_rdata_q, rob_rdata_d;

  logic       sel_vid, sel_rob, sel_ed;
  logic [3:0] sel_row;
  logic [4:0] sel_col;
  logic       sel_we;
  logic [3:0] sel_wdata;
  logic       sel_oor;
  logic [8:0] sel_addr;

  // Winner selection: video first, then round-robin between robot and editor.
  always_comb begin
    sel_vid = 1'b0;
    sel_rob = 1'b0;
    sel_ed  = 1'b0;
    if (state_q == ST_RUN && !bus.map_reload) begin
      if (bus.vid_req) begin
        sel_vid = 1'b1;
      end else if (bus.rob_req && bus.ed_req) begin
        sel_rob = (rr_last_q == RR_ED);
        sel_ed  = (rr_last_q == RR_ROB);
      end else begin
        sel_rob = bus.rob_req;
        sel_ed  = bus.ed_req;
      end
    end
  end

  always_comb begin
    sel_row   = bus.vid_row;
    sel_col   = bus.vid_col;
    sel_we    = 1'b0;
    sel_wdata = bus.rob_wdata;
    if (sel_rob) begin
      sel_row   = bus.rob_row;
      sel_col   = bus.rob_col;
      sel_we    = bus.rob_we;
      sel_wdata = bus.rob_wdata;
    end else if (sel_ed) begin
      sel_row   = bus.ed_row;
      sel_col   = bus.ed_col;
      sel_we    = 1'b1;
      sel_wdata = bus.ed_wdata;
    end
  end

  assign sel_addr = 9'(sel_row) * COLS9 + 9'(sel_col);
  assign sel_oor  = (sel_row == 4'd0) || (32'(sel_row) > ROWS) ||
                    (sel_col == 5'd0) || (32'(sel_col) > COLS);

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    rr_last_d     = rr_last_q;
    ram_addr_d    = ram_addr_q;
    vid_pend_d    = 1'b0;
    rob_pend_d    = 1'b0;
    rd_oor_d      = 1'b0;
    addr_err_d    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = 4'h0;
    bus.rom_addr  = 9'd0;
    if (state_q == ST_INIT) begin
      if (k_q < DEPTH9) bus.rom_addr = k_q;
      // ROM data lags its address by a cycle, so cycle k writes word k-1.
      if (k_q != 9'd0) begin
        ram_addr_d    = k_q - 9'd1;
        bus.ram_we    = 1'b1;
        bus.ram_wdata = bus.rom_data;
      end
      if (k_q == DEPTH9) begin
        state_d = ST_RUN;
        k_d     = 9'd0;
      end else begin
        k_d = k_q + 9'd1;
      end
    end else if (bus.map_reload) begin
      state_d = ST_INIT;
      k_d     = 9'd0;
    end else if (sel_vid || sel_rob || sel_ed) begin
      // Out-of-range accesses still take the slot but never write.
      ram_addr_d    = sel_addr;
      bus.ram_we    = sel_we && !sel_oor;
      bus.ram_wdata = sel_wdata;
      vid_pend_d    = sel_vid;
      rob_pend_d    = sel_rob && !sel_we;
      rd_oor_d      = sel_oor;
      addr_err_d    = sel_oor;
      if (sel_rob) rr_last_d = RR_ROB;
      if (sel_ed)  rr_last_d = RR_ED;
    end
    if (reset) begin
      bus.ram_we    = 1'b0;
      bus.ram_wdata = 4'h0;
      bus.rom_addr  = 9'd0;
      ram_addr_d    = 9'd0;
    end
  end

  // Read data is taken straight from the RAM in T+1 and held afterwards.
  always_comb begin
    vid_rdata_d = vid_rdata_q;
    rob_rdata_d = rob_rdata_q;
    if (vid_pend_q) vid_rdata_d = rd_oor_q ? WALL_CODE : bus.ram_rdata;
    if (rob_pend_q) rob_rdata_d = rd_oor_q ? WALL_CODE : bus.ram_rdata;
    if (reset) begin
      vid_rdata_d = 4'h0;
      rob_rdata_d = 4'h0;
    end
  end

  assign bus.ram_addr   = ram_addr_d;
  assign bus.ready      = (state_q == ST_RUN) && !reset;
  assign bus.rob_gnt    = sel_rob && !reset;
  assign bus.ed_gnt     = sel_ed && !reset;
  assign bus.vid_rvalid = vid_pend_q && !reset;
  assign bus.rob_rvalid = rob_pend_q && !reset;
  assign bus.vid_rdata  = vid_rdata_d;
  assign bus.rob_rdata  = rob_rdata_d;
  assign bus.addr_err   = addr_err_q && !reset;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q     <= ST_INIT;
      k_q         <= 9'd0;
      rr_last_q   <= RR_ED;
      ram_addr_q  <= 9'd0;
      vid_pend_q  <= 1'b0;
      rob_pend_q  <= 1'b0;
      rd_oor_q    <= 1'b0;
      addr_err_q  <= 1'b0;
      vid_rdata_q <= 4'h0;
      rob_rdata_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      rr_last_q   <= rr_last_d;
      ram_addr_q  <= ram_addr_d;
      vid_pend_q  <= vid_pend_d;
      rob_pend_q  <= rob_pend_d;
      rd_oor_q    <= rd_oor_d;
      addr_err_q  <= addr_err_d;
      vid_rdata_q <= vid_rdata_d;
      rob_rdata_q <= rob_rdata_d;
    end
  end
endmodule

// File: doc/map_access_arbiter.md
Name: map_access_arbiter

Overview:
- Owns the single-port map RAM that holds the 16x20 grid of 4-bit cells.
- Loads the RAM from the initial-map ROM after reset or on request.
- Then arbitrates three requesters, one RAM access per cycle: video sprite reader, robot sensor/trash-removal port (read/write) and cursor editor (write-only).
- Converts (row, col) to the linear address row*COLS+col and filters out-of-range coordinates.

Parameters:
ROWS, 15, highest valid grid row (valid rows 1..ROWS; row 0 holds robot start data)
COLS, 20, highest valid grid column (valid cols 1..COLS)
MAP_DEPTH, 321, RAM/ROM words copied during init (addresses 0..MAP_DEPTH-1)
WALL_CODE, 4'b0000, data returned for out-of-range reads

Ports:
clock_50  in  1  system clock
reset  in  1  synchronous, active-high reset
map_reload  in  1  pulse: re-copy ROM into RAM
ready  out  1  high when in RUN
rom_addr  out  9  initial-map ROM address
rom_data  in  4  ROM data, valid 1 cycle after rom_addr
vid_req  in  1  video read request
vid_row  in  4  video cell row
vid_col  in  5  video cell column
vid_rvalid  out  1  video read data valid
vid_rdata  out  4  video read data
rob_req  in  1  robot request
rob_we  in  1  1 = write, 0 = read
rob_row  in  4  robot cell row
rob_col  in  5  robot cell column
rob_wdata  in  4  robot write data
rob_gnt  out  1  robot access issued this cycle
rob_rvalid  out  1  robot read data valid
rob_rdata  out  4  robot read data
ed_req  in  1  editor write request
ed_row  in  4  editor cell row
ed_col  in  5  editor cell column
ed_wdata  in  4  editor write data
ed_gnt  out  1  editor write issued this cycle
ram_addr  out  9  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  4  RAM write data
ram_rdata  in  4  RAM read data, valid 1 cycle after address
addr_err  out  1  one-cycle pulse: out-of-range access granted previous cycle

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-INIT): ready=0, all gnt/rvalid=0, rdata=0, ram_we=0, ram_addr=0, rom_addr=0, addr_err=0, init counter=0, rr_last=editor. The first cycle after reset is in INIT.
- States: INIT, RUN.
- INIT:
  - Counter k runs 0..MAP_DEPTH.
  - rom_addr=k for k<MAP_DEPTH.
  - In cycle k>=1: ram_addr=k-1, ram_wdata=rom_data, ram_we=1.
  - Duration is exactly MAP_DEPTH+1 cycles, then RUN with ready=1.
  - No grants during INIT; all requests are held off; map_reload is ignored.
- RUN:
  - map_reload=1: no grant that cycle; next state INIT with k=0. A read granted the previous cycle still returns its rvalid.
  - Otherwise one winner per cycle:
    - vid_req always wins.
    - Else if rob_req and ed_req both high: round-robin, winner is the one not granted last (rr_last updates on every robot or editor grant).
    - Else the single requester wins.
  - Video has no grant signal. Video loses no cycles; robot/editor may starve while vid_req is held (accepted by design).
- Grant timing (Mealy): rob_gnt/ed_gnt and ram_addr/ram_we/ram_wdata are driven combinationally in grant cycle T. Requesters hold req and fields stable until gnt. Deassertion before gnt is legal and drops the request.
- Reads: rvalid for the winner is asserted in T+1 for exactly 1 cycle. rdata = ram_rdata in T+1 and holds its last value otherwise.
- Address: ram_addr = row*COLS + col, computed at 9 bits, no truncation for valid inputs.
- Range check: out-of-range means row=0 or row>ROWS or col=0 or col>COLS. An out-of-range access is still granted/serviced and consumes the slot, but:
  - ram_we=0 (write dropped);
  - read rdata=WALL_CODE at T+1 with rvalid=1;
  - addr_err=1 at T+1.
- Idle RUN cycle: ram_we=0, ram_addr holds its previous value.

Test Plan:
- Reset, ROM word i = i[3:0] -> ready rises exactly MAP_DEPTH+1 cycles after reset release; RAM[21]=4'h5, RAM[320]=4'h0.
- RUN, rob read row=1 col=1 with RAM[21]=4'h3 -> rob_gnt in T, ram_addr=21, rob_rvalid=1 and rob_rdata=3 in T+1.
- vid_req, rob_req and ed_req all high for 3 cycles -> vid serviced every cycle, rob_gnt/ed_gnt stay 0. Drop vid -> rob_gnt, then ed_gnt, then rob_gnt.
- ed write row=15 col=20 data=4'h6 -> ram_addr=320, ram_we=1. ed write col=21 -> ed_gnt=1, ram_we=0, addr_err at T+1.
- vid read row=0 col=5 -> vid_rvalid=1, vid_rdata=4'h0, addr_err=1.
- map_reload while rob_req is held -> no grant that cycle, ready=0 next cycle, rob_gnt only after re-init. Reset asserted mid-INIT -> init restarts at k=0.
